// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared types, constants and palette mirroring for the PPU pixel mux
package ppu_pkg;

    localparam int PAL_DEPTH = 32;
    localparam int PIX_LAT   = 2;

    typedef logic [4:0] pal_addr_t;
    typedef logic [5:0] nes_color_t;
    typedef logic [3:0] color_idx_t;

    localparam pal_addr_t  BACKDROP_ADDR  = 5'h00;
    localparam logic [8:0] LEFT_CLIP_COLS = 9'd8;
    localparam logic [8:0] VISIBLE_ROWS   = 9'd240;

    // Sprite colour 0 of each sprite palette shares storage with the matching bg entry.
    function automatic pal_addr_t pal_mirror(input pal_addr_t a);
        return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
    endfunction

endpackage

// File: rtl/ppu_palette_ram.sv
// rtl/ppu_palette_ram.sv - 32x6 palette storage with mirrored write, CPU read and bypassed pixel read
module ppu_palette_ram
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [5:0] wdata,
    input  logic [4:0] cpu_addr,
    output logic [5:0] cpu_rdata,
    input  logic [4:0] pix_addr,
    output logic [5:0] pix_rdata
);

    nes_color_t mem [PAL_DEPTH];
    pal_addr_t  wa;
    pal_addr_t  pa;

    assign wa        = pal_mirror(waddr);
    assign pa        = pal_mirror(pix_addr);
    assign cpu_rdata = mem[pal_mirror(cpu_addr)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wdata;
        end
    end

    // A same-entry write in the read cycle is forwarded so the pixel sees the new colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_rdata <= '0;
        end else if (we && (wa == pa)) begin
            pix_rdata <= wdata;
        end else begin
            pix_rdata <= mem[pa];
        end
    end

endmodule

// File: rtl/ppu_pixel_mux.sv
// rtl/ppu_pixel_mux.sv - bg/sprite priority merge, palette lookup and sprite-0 hit; PPU_GRAYSCALE_EN adds output grayscale masking
module ppu_pixel_mux
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_valid_in,
    input  logic [8:0] row,
    input  logic [8:0] col,
    input  logic [3:0] bg_color_idx,
    input  logic [3:0] sp_color_idx,
    input  logic       sp_priority,
    input  logic       sp_is_zero,
    input  logic       bg_en,
    input  logic       sp_en,
    input  logic       bg_left_en,
    input  logic       sp_left_en,
    input  logic       grayscale,
    input  logic       pal_we,
    input  logic [4:0] pal_addr,
    input  logic [5:0] pal_wdata,
    output logic [5:0] pal_rdata,
    output logic       pix_valid_out,
    output logic [8:0] pix_row,
    output logic [8:0] pix_col,
    output logic [5:0] pix_color,
    output logic       sp0_hit,
    input  logic       sp0_clr
);

    logic       left_zone;
    color_idx_t bg_eff;
    color_idx_t sp_eff;
    logic       bg_opq;
    logic       sp_opq;
    logic       hit_set;
    pal_addr_t  addr_d;

    logic       s1_valid;
    logic [8:0] s1_row;
    logic [8:0] s1_col;
    pal_addr_t  s1_addr;
    nes_color_t ram_color;

    assign left_zone = (col < LEFT_CLIP_COLS);
    assign bg_eff    = (!bg_en || (left_zone && !bg_left_en)) ? 4'h0 : bg_color_idx;
    assign sp_eff    = (!sp_en || (left_zone && !sp_left_en)) ? 4'h0 : sp_color_idx;
    assign bg_opq    = |bg_eff[1:0];
    assign sp_opq    = |sp_eff[1:0];

    always_comb begin
        addr_d = BACKDROP_ADDR;
        case ({bg_opq, sp_opq})
            2'b10:   addr_d = {1'b0, bg_eff};
            2'b01:   addr_d = {1'b1, sp_eff};
            2'b11:   addr_d = sp_priority ? {1'b0, bg_eff} : {1'b1, sp_eff};
            default: addr_d = BACKDROP_ADDR;
        endcase
    end

    // Dot 255 never reports a hit, matching the original PPU's edge-of-screen quirk.
    assign hit_set = pix_valid_in && sp_is_zero && bg_opq && sp_opq &&
                     (col != 9'd255) && (row < VISIBLE_ROWS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= pix_valid_in;
            s1_row   <= row;
            s1_col   <= col;
            s1_addr  <= addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp0_hit <= 1'b0;
        end else if (sp0_clr) begin
            sp0_hit <= 1'b0;
        end else if (hit_set) begin
            sp0_hit <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid_out <= 1'b0;
            pix_row       <= '0;
            pix_col       <= '0;
        end else begin
            pix_valid_out <= s1_valid;
            pix_row       <= s1_row;
            pix_col       <= s1_col;
        end
    end

    ppu_palette_ram u_pal (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (pal_we),
        .waddr     (pal_addr),
        .wdata     (pal_wdata),
        .cpu_addr  (pal_addr),
        .cpu_rdata (pal_rdata),
        .pix_addr  (s1_addr),
        .pix_rdata (ram_color)
    );

`ifdef PPU_GRAYSCALE_EN
    logic s2_gray;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_gray <= 1'b0;
        end else begin
            s2_gray <= grayscale;
        end
    end

    assign pix_color = s2_gray ? (ram_color & 6'h30) : ram_color;
`else
    logic unused_grayscale;

    assign unused_grayscale = grayscale;
    assign pix_color        = ram_color;
`endif

endmodule

// File: tb/tb_ppu_pixel_mux.sv
// tb/tb_ppu_pixel_mux.sv - table-driven and directed self-checking bench for ppu_pixel_mux
module tb_ppu_pixel_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_valid_in;
    logic [8:0] row;
    logic [8:0] col;
    logic [3:0] bg_color_idx;
    logic [3:0] sp_color_idx;
    logic       sp_priority;
    logic       sp_is_zero;
    logic       bg_en;
    logic       sp_en;
    logic       bg_left_en;
    logic       sp_left_en;
    logic       grayscale;
    logic       pal_we;
    logic [4:0] pal_addr;
    logic [5:0] pal_wdata;
    logic [5:0] pal_rdata;
    logic       pix_valid_out;
    logic [8:0] pix_row;
    logic [8:0] pix_col;
    logic [5:0] pix_color;
    logic       sp0_hit;
    logic       sp0_clr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ppu_pixel_mux dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pix_valid_in  (pix_valid_in),
        .row           (row),
        .col           (col),
        .bg_color_idx  (bg_color_idx),
        .sp_color_idx  (sp_color_idx),
        .sp_priority   (sp_priority),
        .sp_is_zero    (sp_is_zero),
        .bg_en         (bg_en),
        .sp_en         (sp_en),
        .bg_left_en    (bg_left_en),
        .sp_left_en    (sp_left_en),
        .grayscale     (grayscale),
        .pal_we        (pal_we),
        .pal_addr      (pal_addr),
        .pal_wdata     (pal_wdata),
        .pal_rdata     (pal_rdata),
        .pix_valid_out (pix_valid_out),
        .pix_row       (pix_row),
        .pix_col       (pix_col),
        .pix_color     (pix_color),
        .sp0_hit       (sp0_hit),
        .sp0_clr       (sp0_clr)
    );

    typedef struct {
        logic [8:0] row;
        logic [8:0] col;
        logic [3:0] bg;
        logic [3:0] sp;
        logic       prio;
        logic       bg_en;
        logic       sp_en;
        logic       bgl;
        logic       spl;
        logic [5:0] exp_color;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pal_write(input logic [4:0] a, input logic [5:0] d);
        pal_we    = 1'b1;
        pal_addr  = a;
        pal_wdata = d;
        tick();
        pal_we    = 1'b0;
    endtask

    task automatic set_pix(input logic [8:0] r, input logic [8:0] c, input logic [3:0] bg,
                           input logic [3:0] sp, input logic prio);
        pix_valid_in = 1'b1;
        row          = r;
        col          = c;
        bg_color_idx = bg;
        sp_color_idx = sp;
        sp_priority  = prio;
    endtask

    initial begin
        vecs[0]  = '{9'd10, 9'd20, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'h0F};
        vecs[1]  = '{9'd10, 9'd21, 4'h5, 4'h7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h21};
        vecs[2]  = '{9'd11, 9'd22, 4'h5, 4'h7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'h16};
        vecs[3]  = '{9'd12, 9'd3,  4'h6, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h0F};
        vecs[4]  = '{9'd12, 9'd8,  4'h6, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'h2C};
        vecs[5]  = '{9'd13, 9'd30, 4'h5, 4'h7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'h16};
        vecs[6]  = '{9'd14, 9'd31, 4'h5, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'h21};
        vecs[7]  = '{9'd15, 9'd3,  4'h0, 4'h7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h0F};
        vecs[8]  = '{9'd16, 9'd40, 4'h4, 4'h7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h16};
        vecs[9]  = '{9'd17, 9'd41, 4'h5, 4'h4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'h21};
        vecs[10] = '{9'd200, 9'd300, 4'h1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'h12};
        vecs[11] = '{9'd261, 9'd340, 4'h1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h11};

        rst_n = 1'b0;
        pix_valid_in = 1'b0; row = '0; col = '0; bg_color_idx = '0; sp_color_idx = '0;
        sp_priority = 1'b0; sp_is_zero = 1'b0; bg_en = 1'b1; sp_en = 1'b1;
        bg_left_en = 1'b1; sp_left_en = 1'b1; grayscale = 1'b0;
        pal_we = 1'b0; pal_addr = '0; pal_wdata = '0; sp0_clr = 1'b0;
        tick();
        tick();
        chk("reset valid", {31'd0, pix_valid_out}, 0);
        chk("reset color", {26'd0, pix_color}, 0);
        chk("reset row",   {23'd0, pix_row}, 0);
        chk("reset sp0",   {31'd0, sp0_hit}, 0);
        rst_n = 1'b1;
        tick();

        pal_write(5'h10, 6'h0F);
        pal_write(5'h05, 6'h21);
        pal_write(5'h17, 6'h16);
        pal_write(5'h06, 6'h2C);
        pal_write(5'h01, 6'h11);
        pal_write(5'h12, 6'h12);
        pal_write(5'h03, 6'h03);
        pal_write(5'h09, 6'h2A);

        pal_addr = 5'h00; #1;
        chk("rdata 00 via 10 mirror", {26'd0, pal_rdata}, 32'h0F);
        pal_addr = 5'h10; #1;
        chk("rdata 10 mirror", {26'd0, pal_rdata}, 32'h0F);
        pal_addr = 5'h14; #1;
        chk("rdata 14 mirror", {26'd0, pal_rdata}, 32'h00);
        pal_addr = 5'h17; #1;
        chk("rdata 17", {26'd0, pal_rdata}, 32'h16);

        for (int i = 0; i < 12; i++) begin
            set_pix(vecs[i].row, vecs[i].col, vecs[i].bg, vecs[i].sp, vecs[i].prio);
            bg_en      = vecs[i].bg_en;
            sp_en      = vecs[i].sp_en;
            bg_left_en = vecs[i].bgl;
            sp_left_en = vecs[i].spl;
            tick();
            pix_valid_in = 1'b0;
            chk($sformatf("vec%0d early valid", i), {31'd0, pix_valid_out}, 0);
            tick();
            chk($sformatf("vec%0d color", i), {26'd0, pix_color}, {26'd0, vecs[i].exp_color});
            chk($sformatf("vec%0d valid", i), {31'd0, pix_valid_out}, 1);
            chk($sformatf("vec%0d row", i), {23'd0, pix_row}, {23'd0, vecs[i].row});
            chk($sformatf("vec%0d col", i), {23'd0, pix_col}, {23'd0, vecs[i].col});
        end
        bg_en = 1'b1; sp_en = 1'b1; bg_left_en = 1'b1; sp_left_en = 1'b1;

        // sprite-0 hit set, hold, clear, and blocked cases
        set_pix(9'd100, 9'd50, 4'h1, 4'h2, 1'b1);
        sp_is_zero = 1'b1;
        tick();
        chk("sp0 set", {31'd0, sp0_hit}, 1);
        sp_is_zero = 1'b0;
        pix_valid_in = 1'b0;
        tick(); tick(); tick();
        chk("sp0 held", {31'd0, sp0_hit}, 1);
        sp0_clr = 1'b1;
        tick();
        sp0_clr = 1'b0;
        chk("sp0 cleared", {31'd0, sp0_hit}, 0);

        set_pix(9'd100, 9'd255, 4'h1, 4'h2, 1'b0);
        sp_is_zero = 1'b1;
        tick();
        chk("sp0 col255", {31'd0, sp0_hit}, 0);
        set_pix(9'd240, 9'd50, 4'h1, 4'h2, 1'b0);
        tick();
        chk("sp0 row240", {31'd0, sp0_hit}, 0);
        set_pix(9'd100, 9'd50, 4'h1, 4'h0, 1'b0);
        tick();
        chk("sp0 sp transparent", {31'd0, sp0_hit}, 0);
        set_pix(9'd100, 9'd50, 4'h1, 4'h2, 1'b0);
        sp0_clr = 1'b1;
        tick();
        chk("sp0 clr wins", {31'd0, sp0_hit}, 0);
        sp0_clr = 1'b0;
        pix_valid_in = 1'b0;
        tick();
        chk("sp0 needs valid", {31'd0, sp0_hit}, 0);
        set_pix(9'd239, 9'd254, 4'h1, 4'h2, 1'b0);
        tick();
        chk("sp0 row239 col254", {31'd0, sp0_hit}, 1);
        sp_is_zero = 1'b0;
        pix_valid_in = 1'b0;
        sp0_clr = 1'b1;
        tick();
        sp0_clr = 1'b0;

        // write to entry 3 in the same cycle stage 2 reads it
        set_pix(9'd20, 9'd100, 4'h3, 4'h0, 1'b0);
        tick();
        pix_valid_in = 1'b0;
        pal_we = 1'b1; pal_addr = 5'h03; pal_wdata = 6'h2B;
        tick();
        pal_we = 1'b0;
        chk("bypass color", {26'd0, pix_color}, 32'h2B);
        #1;
        chk("bypass rdata", {26'd0, pal_rdata}, 32'h2B);

        set_pix(9'd21, 9'd101, 4'h9, 4'h0, 1'b0);
        grayscale = 1'b1;
        tick();
        pix_valid_in = 1'b0;
        tick();
`ifdef PPU_GRAYSCALE_EN
        chk("grayscale masked", {26'd0, pix_color}, 32'h20);
`else
        chk("grayscale ignored", {26'd0, pix_color}, 32'h2A);
`endif
        pal_addr = 5'h09; #1;
        chk("grayscale rdata", {26'd0, pal_rdata}, 32'h2A);
        grayscale = 1'b0;

        // reset mid-stream
        set_pix(9'd30, 9'd60, 4'h1, 4'h2, 1'b0);
        sp_is_zero = 1'b1;
        tick(); tick();
        chk("pre-reset valid", {31'd0, pix_valid_out}, 1);
        chk("pre-reset sp0", {31'd0, sp0_hit}, 1);
        rst_n = 1'b0;
        #1;
        chk("in-reset valid", {31'd0, pix_valid_out}, 0);
        chk("in-reset color", {26'd0, pix_color}, 0);
        chk("in-reset row", {23'd0, pix_row}, 0);
        chk("in-reset col", {23'd0, pix_col}, 0);
        chk("in-reset sp0", {31'd0, sp0_hit}, 0);
        pal_addr = 5'h05; #1;
        chk("in-reset palette", {26'd0, pal_rdata}, 0);
        sp_is_zero = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post-reset valid c1", {31'd0, pix_valid_out}, 0);
        tick();
        chk("post-reset valid c2", {31'd0, pix_valid_out}, 1);
        chk("post-reset color", {26'd0, pix_color}, 0);
        pix_valid_in = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ppu_pixel_mux.md
Name: ppu_pixel_mux

Overview:
- Downstream of the background pixel stage: merges its 4-bit background index with the sprite unit's 4-bit index under priority and clipping rules.
- Looks up the 6-bit NES system colour in an internal 32-entry palette RAM that the CPU writes through PPUDATA at $3F00-$3F1F.
- Detects sprite-0 hit; output feeds the NES-palette-to-RGB/VGA stage.
- Two-stage pipeline, one pixel per clock.

Parameters:
- PAL_DEPTH, 32, palette entries (address width 5); fixed by hardware, kept as a parameter for the package constant.
- LAT, 2, pixel-in to pixel-out latency in cycles; informational, must equal 2.

Ports:
- clk  in  1  PPU clock
- rst_n  in  1  asynchronous active-low reset
- pix_valid_in  in  1  row/col/indices valid this cycle
- row  in  9  scanline of incoming pixel (0-261)
- col  in  9  dot of incoming pixel (0-340)
- bg_color_idx  in  4  {bg palette, colour}; low bits 00 = transparent
- sp_color_idx  in  4  {sprite palette, colour}; low bits 00 = transparent
- sp_priority  in  1  1 = sprite behind opaque background
- sp_is_zero  in  1  sprite pixel comes from OAM sprite 0
- bg_en, sp_en  in  1 each  PPUMASK show-background / show-sprites
- bg_left_en, sp_left_en  in  1 each  PPUMASK show in leftmost 8 dots
- grayscale  in  1  PPUMASK bit 0 (used only with option)
- pal_we  in  1  CPU palette write strobe
- pal_addr  in  5  CPU palette address (PPU addr[4:0])
- pal_wdata  in  6  write data (CPU bits [5:0])
- pal_rdata  out  6  combinational read of pal_addr (mirrored)
- pix_valid_out  out  1  output pixel valid
- pix_row, pix_col  out  9 each  coordinates of output pixel
- pix_color  out  6  NES system colour
- sp0_hit  out  1  sticky sprite-0 hit flag (PPUSTATUS bit 6)
- sp0_clr  in  1  clear sp0_hit (pre-render line, dot 1)

Behaviour:
- Reset: all pipeline registers, pix_valid_out, pix_row, pix_col, pix_color and sp0_hit go to 0; all palette entries go to 0.
- Address mirroring: entries $10/$14/$18/$1C alias $00/$04/$08/$0C for both writes and reads.
- Stage 1 (registered at the end of cycle N):
  - Effective bg = bg_color_idx, forced to 0 if !bg_en, or if col<8 and !bg_left_en.
  - Effective sp = sp_color_idx, forced to 0 if !sp_en, or if col<8 and !sp_left_en.
  - Opaque means low 2 bits nonzero.
  - Palette address:
    - neither opaque -> 5'h00
    - only bg opaque -> {0, bg}
    - only sp opaque -> {1, sp}
    - both opaque -> sp_priority ? {0, bg} : {1, sp}
- Stage 2 (cycle N+1): pix_color = palette[mirror(addr)], registered. pix_valid_out, pix_row and pix_col are delayed to match, so the pixel appears 2 cycles after input.
- Pipeline is free-running and has no stall. Invalid inputs still propagate, with valid = 0.
- Palette write: synchronous on the clk edge when pal_we is 1.
- Write/read collision: a write and a stage-2 read of the same mirrored entry in the same cycle returns the NEW data (write-through bypass).
- pal_rdata is combinational and reflects the current array contents.
- Sprite-0 hit fires, in stage 1, when all of the following hold:
  - pix_valid_in, sp_is_zero, bg opaque, sp opaque (after clipping/enable)
  - col != 255, row < 240
  - sp_priority is ignored.
- sp0_hit sets one cycle after the qualifying input and stays set until sp0_clr.
- Simultaneous set and sp0_clr in the same cycle: clear wins.
- Reset mid-frame: pipeline contents are discarded and output is valid=0 for 2 cycles after reset release.

Optional Feature:
- Macro PPU_GRAYSCALE_EN.
- When defined: if grayscale is 1 at stage 2, pix_color = palette value & 6'h30. The mask is applied to the output only; pal_rdata is unaffected.
- When undefined: the grayscale port exists but is ignored, and colour is passed through unmasked.

Decomposition:
- Shared package ppu_pkg holds:
  - pal_addr_t (5-bit), nes_color_t (6-bit), color_idx_t (4-bit)
  - PAL_DEPTH, BACKDROP_ADDR = 5'h00, LEFT_CLIP_COLS = 8, VISIBLE_ROWS = 240
  - function pal_mirror(pal_addr_t)
- One sub-module, ppu_palette_ram: 32x6 register array, mirrored write port, combinational CPU read port, registered pixel read with write bypass.

Test Plan:
- Write $3F10=6'h0F then read pal_addr 5'h00 -> pal_rdata=6'h0F; bg=4'h0, sp=4'h0 -> pix_color=6'h0F two cycles later.
- bg=4'h5 with palette[5]=6'h21, sp=4'h7 with palette[$17]=6'h16, sp_priority=1 -> 6'h21; sp_priority=0 -> 6'h16.
- col=3, bg_left_en=0, bg=4'h6, sp=4'h0 -> backdrop colour; same at col=8 -> palette[6].
- sp_is_zero=1, bg=4'h1, sp=4'h2, row=100, col=50 -> sp0_hit=1 next cycle and held. At col=255 -> no set. sp0_clr asserted in the same cycle as a qualifying set -> sp0_hit=0.
- pal_we to entry 5'h03 in the same cycle stage 2 reads 5'h03 -> pix_color equals new pal_wdata.
- With PPU_GRAYSCALE_EN, grayscale=1, palette value 6'h2A -> pix_color=6'h20. Assert rst_n low mid-stream -> all outputs 0 immediately, pix_valid_out=0 for 2 cycles after release.
